// File: rtl/cbus_axi_bridge_pkg.sv
// Shared definitions for the CBus-to-AXI4 master bridge.
//   axi_burst_t    : AXI burst encodings (FIXED is re-issued as INCR by the bridge)
//   AXI_RESP_*     : AXI response codes
//   bridge_state_t : bridge FSM states
//   AXI_CACHE/PROT : constant attributes driven on AR/AW
package cbus_axi_bridge_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [3:0] AXI_CACHE = 4'b0011;  // normal non-cacheable bufferable
  localparam logic [2:0] AXI_PROT  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5,
    ST_DONE    = 3'd6
  } bridge_state_t;

  // SLVERR and DECERR both count as a failed beat.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/cbus_axi_beat_ctr.sv
// Beat counter shared by the read and write paths of the bridge.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : latch a new burst length (beats-1) and clear the count
//   len_in    : requested beats-1 in AXI encoding
//   inc       : one beat transferred
//   is_last   : current beat is the final one of the (clamped) burst
//   len_axi   : clamped beats-1 to drive on arlen/awlen
//   len_over  : request exceeded MAX_LEN and was clamped
module cbus_axi_beat_ctr #(
  parameter  int MAX_LEN = 16,
  localparam int CNT_W   = $clog2(MAX_LEN) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] len_in,
  input  logic       inc,
  output logic       is_last,
  output logic [7:0] len_axi,
  output logic       len_over
);

  localparam logic [7:0] LEN_CAP = 8'(MAX_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;

  function automatic logic [CNT_W-1:0] sat_len(input logic [7:0] len);
    return (len > LEN_CAP) ? CNT_W'(LEN_CAP) : CNT_W'(len);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      len_q    <= '0;
      len_over <= 1'b0;
    end else if (load) begin
      cnt_q    <= '0;
      len_q    <= sat_len(len_in);
      len_over <= (len_in > LEN_CAP);
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign is_last = (cnt_q == len_q);
  assign len_axi = 8'(len_q);

endmodule

// File: rtl/cbus_axi_bridge.sv
// CBus-to-AXI4 master bridge, one transaction outstanding.
//   aclk, areset : clock, asynchronous active-high reset
//   creq_*       : core request (held valid until the final beat completes;
//                  data/strobe advance after each write-beat cresp_ready)
//   cresp_*      : per-beat completion, last-beat flag, read data, error
//   ar*/r*       : AXI4 read address / read data channels
//   aw*/w*/b*    : AXI4 write address / data / response channels
module cbus_axi_bridge
  import cbus_axi_bridge_pkg::*;
#(
  parameter  int              DATA_W  = 64,
  parameter  int              ADDR_W  = 64,
  parameter  int              ID_W    = 4,
  parameter  logic [ID_W-1:0] AXI_ID  = '0,
  parameter  int              MAX_LEN = 16,
  localparam int              STRB_W  = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  // core side
  input  logic              creq_valid,
  input  logic              creq_is_write,
  input  logic [ADDR_W-1:0] creq_addr,
  input  logic [2:0]        creq_size,
  input  logic [7:0]        creq_len,
  input  logic [1:0]        creq_burst,
  input  logic [STRB_W-1:0] creq_strobe,
  input  logic [DATA_W-1:0] creq_data,
  output logic              cresp_ready,
  output logic              cresp_last,
  output logic [DATA_W-1:0] cresp_data,
  output logic              cresp_err,
  // AXI read address
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  bridge_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  axi_burst_t        burst_q;
  logic              err_q;
  logic              w_done_q;

  logic              ctr_load;
  logic              ctr_inc;
  logic              is_last;
  logic [7:0]        len_axi;
  logic              len_over;
  logic              w_hs;
  logic              w_fin;
  logic              r_err;

  cbus_axi_beat_ctr #(
    .MAX_LEN (MAX_LEN)
  ) u_beat_ctr (
    .clk      (aclk),
    .rst      (areset),
    .load     (ctr_load),
    .len_in   (creq_len),
    .inc      (ctr_inc),
    .is_last  (is_last),
    .len_axi  (len_axi),
    .len_over (len_over)
  );

  assign r_err = resp_is_err(rresp);

  // ---- request latch: captured once on leaving IDLE ----
  always_ff @(posedge aclk) begin
    if (ctr_load) begin
      addr_q  <= creq_addr;
      size_q  <= creq_size;
      burst_q <= (creq_burst == BURST_WRAP) ? BURST_WRAP : BURST_INCR;
    end
  end

  // ---- control state ----
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctr_load) begin
        err_q    <= 1'b0;
        w_done_q <= 1'b0;
      end else begin
        if (rvalid && rready && r_err) err_q <= 1'b1;
        if (w_fin) w_done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    arvalid     = 1'b0;
    rready      = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    bready      = 1'b0;
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_err   = 1'b0;
    ctr_load    = 1'b0;
    ctr_inc     = 1'b0;
    w_hs        = 1'b0;
    w_fin       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (creq_valid) begin
          ctr_load = 1'b1;
          state_d  = creq_is_write ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          cresp_ready = 1'b1;
          ctr_inc     = 1'b1;
          // Either the counter or the slave's rlast closes the burst; an
          // rlast that arrives before the counter does is a protocol error.
          if (rlast || is_last) begin
            cresp_last = 1'b1;
            cresp_err  = err_q | r_err | len_over | (rlast & ~is_last);
            state_d    = ST_DONE;
          end
        end
      end
      ST_WR_ADDR: begin
        // W beats may be accepted while AW is still pending; once the final
        // W beat is in, wvalid is held off until AW completes.
        awvalid = 1'b1;
        wvalid  = ~w_done_q;
        w_hs    = ~w_done_q & wready;
        if (w_hs) begin
          cresp_ready = 1'b1;
          ctr_inc     = 1'b1;
          w_fin       = is_last;
        end
        if (awready) state_d = (w_done_q || w_fin) ? ST_WR_RESP : ST_WR_DATA;
      end
      ST_WR_DATA: begin
        wvalid = 1'b1;
        if (wready) begin
          cresp_ready = 1'b1;
          ctr_inc     = 1'b1;
          if (is_last) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          cresp_ready = 1'b1;
          cresp_last  = 1'b1;
          cresp_err   = resp_is_err(bresp) | len_over;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // One dead cycle so the core has dropped creq_valid before IDLE.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cresp_data = rdata;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = len_axi;
  assign arsize  = size_q;
  assign arburst = burst_q;
  assign arlock  = 1'b0;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = len_axi;
  assign awsize  = size_q;
  assign awburst = burst_q;
  assign awlock  = 1'b0;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;

  assign wdata = creq_data;
  assign wstrb = creq_strobe;
  assign wlast = is_last;

endmodule

// File: tb/tb_cbus_axi_bridge.sv
module tb_cbus_axi_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic        creq_valid, creq_is_write;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [7:0]  creq_len;
  logic [1:0]  creq_burst;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready, cresp_last, cresp_err;
  logic [63:0] cresp_data;
  logic [3:0]  arid, awid;
  logic [63:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst;
  logic        arlock, awlock;
  logic [3:0]  arcache, awcache;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  cbus_axi_bridge dut (
    .aclk(aclk), .areset(areset),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
    .creq_size(creq_size), .creq_len(creq_len), .creq_burst(creq_burst),
    .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
    .cresp_err(cresp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial forever #5 aclk = ~aclk;

  typedef struct {
    logic        chk_data;
    logic [63:0] data;
    logic        last;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acks    = 0;
  int   lasts   = 0;

  // slave configuration and observation logs
  int          ar_delay = 0;
  logic [63:0] rdat   [16];
  int          rgaps  [16];
  logic [1:0]  rresps [16];
  int          w_lo = 0;
  int          aw_after_w = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  int          ar_cnt = 0;
  int          aw_cnt = 0;
  logic [7:0]  arlen_log, awlen_log;
  logic [1:0]  arburst_log;
  logic [63:0] araddr_log;
  logic [63:0] w_log_d[$];
  logic        w_log_l[$];
  logic [63:0] wdat [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic chk, input logic [63:0] d,
                                  input logic l, input logic e);
    exp_t x;
    x.chk_data = chk; x.data = d; x.last = l; x.err = e;
    return x;
  endfunction

  // ---- monitor: pops one expectation per cresp_ready ----
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!areset && cresp_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_cresp: got cresp_ready=1, expected no pending beat");
        end else begin
          e = sb_q.pop_front();
          if (e.chk_data) check("cresp_data", cresp_data, e.data);
          check("cresp_last", 64'(cresp_last), 64'(e.last));
          check("cresp_err", 64'(cresp_err), 64'(e.err));
        end
        acks++;
        if (cresp_last) lasts++;
      end
    end
  end

  // ---- AXI read slave ----
  initial begin : rd_slave
    int rs, cnt, beat, gap, nb;
    logic ar_hs, r_hs, arv;
    logic [7:0] arl;
    logic [1:0] arb;
    logic [63:0] ara;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = '0;
    rs = 0; cnt = 0; beat = 0; gap = 0; nb = 0;
    forever begin
      @(posedge aclk);
      ar_hs = arvalid && arready; r_hs = rvalid && rready; arv = arvalid;
      arl = arlen; arb = arburst; ara = araddr;
      #1;
      if (areset) begin
        arready = 0; rvalid = 0; rlast = 0; rs = 0;
      end else begin
        if (rs == 0) begin
          if (arv) begin rs = 1; cnt = 1; end
        end else if (rs == 1) begin
          if (ar_hs) begin
            arready = 0; ar_cnt++; arlen_log = arl; arburst_log = arb; araddr_log = ara;
            rs = 2; beat = 0; nb = int'(arl) + 1; gap = rgaps[0];
          end else begin
            if (cnt >= ar_delay) arready = 1;
            cnt++;
          end
        end else if (r_hs) begin
          rvalid = 0; rlast = 0; beat++;
          if (beat == nb) rs = 0; else gap = rgaps[beat];
        end
        if (rs == 2 && !rvalid) begin
          if (gap == 0) begin
            rvalid = 1; rdata = rdat[beat]; rresp = rresps[beat]; rlast = (beat == nb - 1);
          end else gap--;
        end
      end
    end
  end

  // ---- AXI write slave ----
  initial begin : wr_slave
    logic aw_hs, w_hs, b_hs, awv, wl;
    logic [63:0] wd;
    logic [7:0] awl;
    int aw_done, got_last, wbeats, wcnt;
    awready = 0; wready = 0; bvalid = 0; bresp = '0;
    aw_done = 0; got_last = 0; wbeats = 0; wcnt = 0;
    forever begin
      @(posedge aclk);
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      awv = awvalid; wd = wdata; wl = wlast; awl = awlen;
      #1;
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; aw_done = 0; got_last = 0; wbeats = 0; wcnt = 0;
      end else begin
        if (b_hs) begin bvalid = 0; aw_done = 0; got_last = 0; wbeats = 0; end
        if (aw_hs) begin awready = 0; aw_done = 1; aw_cnt++; awlen_log = awl; end
        if (w_hs) begin
          w_log_d.push_back(wd); w_log_l.push_back(wl); wbeats++;
          if (wl) got_last = 1;
          if (w_lo > 0) wready = 0;
          wcnt = 1;
        end else if (!wready) begin
          if (wcnt >= w_lo) wready = 1; else wcnt++;
        end
        if (awv && !aw_hs && aw_done == 0 && wbeats >= aw_after_w) awready = 1;
        if (aw_done != 0 && got_last != 0 && !bvalid && !b_hs) begin
          bvalid = 1; bresp = b_resp_cfg;
        end
      end
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge aclk);
    $display("FAIL watchdog: got no finish after 20000 cycles, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input int nb, input logic err_last,
                         input logic [7:0] exp_arlen, input logic [1:0] exp_arburst);
    int base, cyc;
    ar_cnt = 0;
    for (int i = 0; i < nb; i++)
      sb_q.push_back(mk_exp(1'b1, rdat[i], i == nb - 1, (i == nb - 1) ? err_last : 1'b0));
    base = lasts;
    creq_is_write = 0; creq_addr = addr; creq_len = len; creq_size = 3'd3;
    creq_burst = burst; creq_valid = 1;
    cyc = 0;
    while (lasts == base && cyc < 400) begin
      @(posedge aclk); #1; cyc++;
    end
    creq_valid = 0;
    check("rd_complete", 64'(lasts - base), 64'd1);
    check("rd_sb_empty", 64'(sb_q.size()), 64'd0);
    check("ar_count", 64'(ar_cnt), 64'd1);
    check("arlen", 64'(arlen_log), 64'(exp_arlen));
    check("arburst", 64'(arburst_log), 64'(exp_arburst));
    check("araddr", araddr_log, addr);
    sb_q.delete();
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] len, input int nb, input logic [1:0] bresp_cfg,
                          input logic exp_err);
    int base_a, base_l, k, cyc;
    aw_cnt = 0; w_log_d.delete(); w_log_l.delete();
    b_resp_cfg = bresp_cfg;
    for (int i = 0; i < nb; i++) sb_q.push_back(mk_exp(1'b0, 64'd0, 1'b0, 1'b0));
    sb_q.push_back(mk_exp(1'b0, 64'd0, 1'b1, exp_err));
    base_a = acks; base_l = lasts;
    creq_is_write = 1; creq_addr = 64'h0000_0000_1000_0040; creq_len = len;
    creq_size = 3'd3; creq_burst = 2'b01; creq_strobe = 8'hFF; creq_data = wdat[0];
    creq_valid = 1;
    cyc = 0;
    while (lasts == base_l && cyc < 400) begin
      @(posedge aclk); #1; cyc++;
      k = acks - base_a;
      if (k > nb - 1) k = nb - 1;
      creq_data = wdat[k];
    end
    creq_valid = 0;
    check("wr_complete", 64'(lasts - base_l), 64'd1);
    check("wr_sb_empty", 64'(sb_q.size()), 64'd0);
    check("aw_count", 64'(aw_cnt), 64'd1);
    check("awlen", 64'(awlen_log), 64'(len));
    check("w_beats", 64'(w_log_d.size()), 64'(nb));
    for (int i = 0; i < nb && i < w_log_d.size(); i++) begin
      check("wdata", w_log_d[i], wdat[i]);
      check("wlast", 64'(w_log_l[i]), 64'(i == nb - 1));
    end
    sb_q.delete();
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin : main
    int base;
    areset = 1; creq_valid = 0; creq_is_write = 0; creq_addr = '0; creq_size = 3'd3;
    creq_len = '0; creq_burst = 2'b01; creq_strobe = 8'hFF; creq_data = '0;
    for (int i = 0; i < 16; i++) begin
      rdat[i] = 64'h5A5A_0000_0000_0000 + 64'(i); rgaps[i] = 0; rresps[i] = 2'b00;
      wdat[i] = 64'h1111_0000_0000_0000 + 64'(i);
    end
    #12;
    // reset state
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_cresp_ready", 64'(cresp_ready), 64'd0);
    check("rst_cresp_last", 64'(cresp_last), 64'd0);
    check("rst_cresp_err", 64'(cresp_err), 64'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    @(posedge aclk); #1;

    // single read, slow arready
    ar_delay = 3;
    rdat[0] = 64'hDEAD_BEEF_CAFE_F00D;
    do_read(64'h0000_0000_8000_0000, 8'd0, 2'b01, 1, 1'b0, 8'd0, 2'b01);
    check("idle_arvalid", 64'(arvalid), 64'd0);
    ar_delay = 0;

    // INCR burst read with rvalid gaps
    rdat[0] = 64'hA0; rdat[1] = 64'hA1; rdat[2] = 64'hA2; rdat[3] = 64'hA3;
    rgaps[0] = 0; rgaps[1] = 2; rgaps[2] = 1; rgaps[3] = 0;
    do_read(64'h0000_0000_8000_0100, 8'd3, 2'b01, 4, 1'b0, 8'd3, 2'b01);
    for (int i = 0; i < 16; i++) rgaps[i] = 0;

    // burst write, slow wready, AW after two W beats
    w_lo = 2; aw_after_w = 2;
    wdat[0] = 64'h0123_4567_89AB_CDEF; wdat[1] = 64'hFEDC_BA98_7654_3210;
    wdat[2] = 64'h0000_FFFF_0000_FFFF; wdat[3] = 64'hAAAA_5555_AAAA_5555;
    do_write(8'd3, 4, 2'b00, 1'b0);

    // write with SLVERR, then a clean read
    w_lo = 0; aw_after_w = 0;
    wdat[0] = 64'h0000_0000_0000_BEEF;
    do_write(8'd0, 1, 2'b10, 1'b1);
    rdat[0] = 64'h1234_5678_9ABC_DEF0;
    do_read(64'h0000_0000_8000_0200, 8'd0, 2'b01, 1, 1'b0, 8'd0, 2'b01);

    // SLVERR on beat 2 of 4; FIXED re-issued as INCR
    rdat[0] = 64'hB0; rdat[1] = 64'hB1; rdat[2] = 64'hB2; rdat[3] = 64'hB3;
    rresps[1] = 2'b10;
    do_read(64'h0000_0000_8000_0300, 8'd3, 2'b00, 4, 1'b1, 8'd3, 2'b01);
    rresps[1] = 2'b00;

    // WRAP burst passes through unchanged
    do_read(64'h0000_0000_8000_0400, 8'd3, 2'b10, 4, 1'b0, 8'd3, 2'b10);

    // over-long request clamped to 16 beats with error
    for (int i = 0; i < 16; i++) rdat[i] = 64'hC000 + 64'(i);
    do_read(64'h0000_0000_8000_1000, 8'd31, 2'b01, 16, 1'b1, 8'd15, 2'b01);

    // reset in the middle of a read burst
    rgaps[2] = 3; rgaps[3] = 3;
    rdat[0] = 64'hD0; rdat[1] = 64'hD1; rdat[2] = 64'hD2; rdat[3] = 64'hD3;
    for (int i = 0; i < 4; i++) sb_q.push_back(mk_exp(1'b1, rdat[i], i == 3, 1'b0));
    base = acks;
    creq_is_write = 0; creq_addr = 64'h0000_0000_8000_2000; creq_len = 8'd3;
    creq_burst = 2'b01; creq_valid = 1;
    for (int c = 0; c < 200 && (acks - base) < 2; c++) begin
      @(posedge aclk); #1;
    end
    check("mid_beats_before_reset", 64'(acks - base), 64'd2);
    #2 areset = 1;
    #1;
    check("mid_rst_rready", 64'(rready), 64'd0);
    check("mid_rst_arvalid", 64'(arvalid), 64'd0);
    check("mid_rst_awvalid", 64'(awvalid), 64'd0);
    check("mid_rst_wvalid", 64'(wvalid), 64'd0);
    check("mid_rst_bready", 64'(bready), 64'd0);
    check("mid_rst_cresp_ready", 64'(cresp_ready), 64'd0);
    sb_q.delete();
    creq_valid = 0;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    for (int i = 0; i < 16; i++) rgaps[i] = 0;
    @(posedge aclk); #1;
    rdat[0] = 64'hE0; rdat[1] = 64'hE1;
    do_read(64'h0000_0000_8000_3000, 8'd1, 2'b01, 2, 1'b0, 8'd1, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
